// File: rtl/mem_port_arbiter.sv
// Unified memory-port arbiter for the pipelined OTTER: one registered bus
// transaction at a time, data before fetch, with load extension, misalignment, timeout and flush.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IReq,
    input  logic [31:0] IAddr,
    input  logic        IFlush,
    output logic [31:0] IRdata,
    output logic        IValid,
    output logic        IErr,
    output logic        IStall,
    input  logic        DReq,
    input  logic        DWe,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWdata,
    input  logic [1:0]  DSize,
    input  logic        DSign,
    output logic [31:0] DRdata,
    output logic        DValid,
    output logic        DErr,
    output logic        DStall,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWdata,
    output logic [1:0]  BusSize,
    input  logic        BusAck,
    input  logic [31:0] BusRdata
);
    typedef enum logic [1:0] {IDLE, D_WAIT, I_WAIT, I_DRAIN} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic        d_sign;
    logic        d_go, i_go, d_mis, i_mis;
    logic        d_issue, d_fault, i_issue, i_fault;
    logic        tmo, ended, d_done, i_done;
    logic [31:0] load_ext;

    assign IStall = IReq & ~IValid;
    assign DStall = DReq & ~DValid;

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (d_issue)      state_nxt = D_WAIT;
                     else if (i_issue) state_nxt = I_WAIT;
            D_WAIT:  if (ended)        state_nxt = IDLE;
            I_WAIT:  if (ended)        state_nxt = IDLE;
                     else if (IFlush)  state_nxt = I_DRAIN;
            I_DRAIN: if (ended)        state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // A completion pulse still on the outputs means the requester has not yet
    // dropped that request, so nothing may issue in that cycle.
    always_comb begin
        d_mis   = (DSize == 2'd1 && DAddr[0]) || (DSize == 2'd2 && DAddr[1:0] != 2'd0)
                  || DSize == 2'd3;
        i_mis   = IAddr[1:0] != 2'd0;
        d_go    = state == IDLE && !IValid && !DValid && DReq;
        i_go    = state == IDLE && !IValid && !DValid && !DReq && IReq && !IFlush;
        d_issue = d_go && !d_mis;
        d_fault = d_go && d_mis;
        i_issue = i_go && !i_mis;
        i_fault = i_go && i_mis;
        tmo     = state != IDLE && !BusAck && cnt == 8'(TIMEOUT - 1);
        ended   = state != IDLE && (BusAck || tmo);
        d_done  = state == D_WAIT && ended;
        i_done  = state == I_WAIT && ended && !IFlush;
    end

    always_comb begin
        case (BusSize)
            2'd0:    load_ext = d_sign ? {24'd0, BusRdata[7:0]}
                                       : {{24{BusRdata[7]}}, BusRdata[7:0]};
            2'd1:    load_ext = d_sign ? {16'd0, BusRdata[15:0]}
                                       : {{16{BusRdata[15]}}, BusRdata[15:0]};
            default: load_ext = BusRdata;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            BusReq   <= 1'b0;
            BusWe    <= 1'b0;
            BusAddr  <= '0;
            BusWdata <= '0;
            BusSize  <= 2'd0;
            d_sign   <= 1'b0;
            cnt      <= '0;
            IValid   <= 1'b0;
            IErr     <= 1'b0;
            IRdata   <= '0;
            DValid   <= 1'b0;
            DErr     <= 1'b0;
            DRdata   <= '0;
        end else begin
            if (d_issue) begin
                BusReq   <= 1'b1;
                BusWe    <= DWe;
                BusAddr  <= DAddr;
                BusWdata <= DWdata;
                BusSize  <= DSize;
                d_sign   <= DSign;
                cnt      <= '0;
            end else if (i_issue) begin
                BusReq   <= 1'b1;
                BusWe    <= 1'b0;
                BusAddr  <= IAddr;
                BusWdata <= '0;
                BusSize  <= 2'd2;
                cnt      <= '0;
            end else if (ended) begin
                BusReq   <= 1'b0;
            end else if (state != IDLE) begin
                cnt      <= cnt + 8'd1;
            end

            DValid <= d_fault || d_done;
            DErr   <= d_fault || (d_done && !BusAck);
            if (d_fault || d_done)
                DRdata <= (d_done && BusAck && !BusWe) ? load_ext : 32'd0;

            IValid <= i_fault || i_done;
            IErr   <= i_fault || (i_done && !BusAck);
            if (i_fault || i_done)
                IRdata <= (i_done && BusAck) ? BusRdata : 32'd0;
        end
    end
endmodule
